// File: rtl/nv_ram_rwsthp_param.sv
// 1R/1W two-stage pipelined RAM model with post-reset clear sequencer, output bypass and valid tracking.
// Build option NV_RAM_WR_FWD_EN: write-first forwarding on a same-address read/write collision.
module nv_ram_rwsthp_param #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic          byp_sel,
  input  logic [DW-1:0] dbyp,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] ra_d;
  logic          rd_pend;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata;
  logic          run;
  logic          wr_hit;
  logic          rd_in_range;
  logic          unused_pwr;

  assign unused_pwr  = ^pwrbus_ram_pd;
  assign run         = (state == RUN);
  assign wr_hit      = we && ({1'b0, wa} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, ra_d} < DEPTH_EXT);

  // Clear sequencer: one entry per cycle, leaves CLEAR on the edge that zeroes the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state     <= RUN;
        init_busy <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Array has no reset so it maps onto block RAM; the sequencer owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (wr_hit) begin
      mem[wa] <= di;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_in_range) begin
      rdata = mem[ra_d];
    end
`ifdef NV_RAM_WR_FWD_EN
    if (rd_in_range && we && (wa == ra_d)) begin
      rdata = di;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_d     <= '0;
      rd_pend  <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (run) begin
      if (re) begin
        ra_d    <= ra;
        rd_pend <= 1'b1;
      end else if (ore) begin
        rd_pend <= 1'b0;
      end
      if (ore) begin
        dout     <= byp_sel ? dbyp : rdata;
        dout_vld <= rd_pend | byp_sel;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// Directed bench for nv_ram_rwsthp_param: behavioural model compared every cycle plus literal pins.
module tb_nv_ram_rwsthp_param;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra = '0;
  logic          re = 1'b0;
  logic          ore = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa = '0;
  logic          we = 1'b0;
  logic [DW-1:0] di = '0;
  logic          byp_sel = 1'b0;
  logic [DW-1:0] dbyp = '0;
  logic [31:0]   pwrbus_ram_pd = 32'h0000_00FF;
  logic          init_busy;

  int errors = 0;
  int checks = 0;

  nv_ram_rwsthp_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout), .dout_vld(dout_vld),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp),
    .pwrbus_ram_pd(pwrbus_ram_pd), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: array contents, pending-read flag and the output the spec rules imply.
  int          busy_left;
  logic [7:0]  m_mem [DEPTH];
  int          m_rad;
  bit          m_pend;
  logic [7:0]  m_dout;
  bit          m_vld;

  always @(posedge clk or posedge rst) begin
    logic [7:0] rd;
    if (rst) begin
      busy_left = DEPTH;
      m_rad = 0;
      m_pend = 0;
      m_dout = 8'h00;
      m_vld = 0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0)
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else begin
      rd = 8'h00;
      if (m_rad < DEPTH) begin
        rd = m_mem[m_rad];
`ifdef NV_RAM_WR_FWD_EN
        if (we && int'(wa) == m_rad) rd = di;
`endif
      end
      if (ore) begin
        m_dout = byp_sel ? dbyp : rd;
        m_vld  = m_pend | byp_sel;
      end
      if (re) begin
        m_rad = int'(ra);
        m_pend = 1;
      end else if (ore) begin
        m_pend = 0;
      end
      if (we && int'(wa) < DEPTH) m_mem[int'(wa)] = di;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_init_busy", {31'd0, init_busy}, {31'd0, busy_left > 0});
      chk("model_dout", {24'd0, dout}, {24'd0, m_dout});
      chk("model_dout_vld", {31'd0, dout_vld}, {31'd0, m_vld});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    re = 0; ore = 0; we = 0; byp_sel = 0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (init_busy && n < 100);
    idle();
    chk(name, n, DEPTH);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    we = 1; wa = AW'(a); di = d;
    step();
    we = 0;
  endtask

  task automatic rd(input int a);
    re = 1; ra = AW'(a);
    step();
    re = 0; ore = 1;
    step();
    ore = 0;
  endtask

  initial begin
    @(negedge clk);
    step();
    chk("rst_dout", {24'd0, dout}, 32'h0);
    chk("rst_vld", {31'd0, dout_vld}, 32'h0);
    chk("rst_busy", {31'd0, init_busy}, 32'h1);

    // Traffic during clear must be ignored.
    we = 1; wa = 5'd3; di = 8'hAA; re = 1; ra = 5'd3; ore = 1;
    rst = 0;
    count_busy("clear_cycles");
    chk("clear_dout_hold", {24'd0, dout}, 32'h0);
    chk("clear_vld_hold", {31'd0, dout_vld}, 32'h0);
    rd(3);
    chk("clear_rd3", {24'd0, dout}, 32'h00);
    chk("clear_rd3_vld", {31'd0, dout_vld}, 32'h1);

    wr(7, 8'h5C);
    rd(7);
    chk("rd7", {24'd0, dout}, 32'h5C);
    step(); step();
    chk("rd7_hold", {24'd0, dout}, 32'h5C);
    chk("rd7_hold_vld", {31'd0, dout_vld}, 32'h1);

    byp_sel = 1; dbyp = 8'h3F; ore = 1;
    step();
    chk("byp_dout", {24'd0, dout}, 32'h3F);
    chk("byp_vld", {31'd0, dout_vld}, 32'h1);
    byp_sel = 0;
    step();
    ore = 0;
    chk("nopend_vld", {31'd0, dout_vld}, 32'h0);

    wr(25, 8'hEE);
    rd(25);
    chk("oor_rd25", {24'd0, dout}, 32'h00);
    wr(8, 8'h77);
    rd(5);
    chk("oor_rd5", {24'd0, dout}, 32'h00);

    wr(4, 8'h11);
    re = 1; ra = 5'd4;
    step();
    re = 0; ore = 1; we = 1; wa = 5'd4; di = 8'h99;
    step();
    idle();
`ifdef NV_RAM_WR_FWD_EN
    chk("collide_dout", {24'd0, dout}, 32'h99);
`else
    chk("collide_dout", {24'd0, dout}, 32'h11);
`endif
    rd(4);
    chk("collide_after", {24'd0, dout}, 32'h99);

    wr(10, 8'h01); wr(11, 8'h02); wr(12, 8'h03);
    re = 1; ra = 5'd10;
    step();
    ore = 1; ra = 5'd11;
    step();
    chk("b2b_0", {24'd0, dout}, 32'h01);
    ra = 5'd12;
    step();
    chk("b2b_1", {24'd0, dout}, 32'h02);
    re = 0;
    step();
    chk("b2b_2", {24'd0, dout}, 32'h03);
    chk("b2b_2_vld", {31'd0, dout_vld}, 32'h1);
    step();
    ore = 0;
    chk("b2b_end_vld", {31'd0, dout_vld}, 32'h0);

    // Reset with a read pending, then again part-way through the clear.
    re = 1; ra = 5'd7;
    step();
    re = 0;
    rst = 1;
    #1;
    chk("rst_mid_read_vld", {31'd0, dout_vld}, 32'h0);
    chk("rst_mid_read_dout", {24'd0, dout}, 32'h0);
    step();
    rst = 0;
    for (int i = 0; i < 10; i++) step();
    rst = 1;
    step();
    rst = 0;
    count_busy("reclear_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, 8'hFF);
      wr(i, 8'h00);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      chk("final_zero", {24'd0, dout}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
